// File: rtl/ddr_burst_rd_master_pkg.sv
// ddr_burst_rd_master_pkg
//   Shared types and defaults for the DDR burst-read master.
//   - Bus-width defaults (data, byte address, burst length field)
//   - FSM state encoding
//   - bytes_per_beat(): byte stride of one data beat
package ddr_burst_rd_master_pkg;

   localparam int DDR_DATA_WIDTH = 64;
   localparam int DDR_ADDR_SIZE  = 32;
   localparam int DDR_LEN_WIDTH  = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DATA  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   function automatic int bytes_per_beat(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/ddr_burst_rd_master_fifo.sv
// sync_fwft_fifo
//   Single-clock first-word-fall-through FIFO. The head word is visible on
//   dout whenever empty is low; dout reads 0 while empty so the stream output
//   shows a clean value after reset.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset (flushes pointers)
//     push, din    write request / data (ignored when full)
//     pop          consume head (ignored when empty)
//     dout         head word
//     count        occupancy, 0..DEPTH
//     full, empty  status flags
module sync_fwft_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 128
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_wr;
   logic          w_rd;

   assign full  = (r_count == (AW+1)'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;
   assign w_wr  = push && !full;
   assign w_rd  = pop && !empty;
   assign dout  = empty ? '0 : r_mem[r_rptr];

   // Storage carries no reset; validity is defined by the pointers alone.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) r_rptr <= r_rptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ddr_burst_rd_master.sv
// ddr_burst_rd_master
//   Burst-read initiator for the DDR user interface. One fetch command
//   (byte base address, total beats) is split into bursts of at most
//   MAX_BURST beats; returned beats are buffered in a FWFT FIFO and streamed
//   out over valid/ready with a last flag. A burst is only requested once the
//   FIFO has room for all of it, so the DDR side never needs backpressure.
//   Optional feature macro: BURST_RD_TIMEOUT_EN adds a per-burst watchdog and
//   the sticky rd_timeout output.
//   Ports:
//     user_clk, user_rst_n             clock, async active-low reset
//     cmd_valid/cmd_ready/cmd_addr/cmd_beats   fetch command
//     burst_read_req/addr/len          burst request (1-cycle req pulse)
//     burst_read_valid/data/finish     returned beats, end-of-burst pulse
//     dout_valid/ready/data/last       output stream
//     done                             1-cycle pulse, command complete
//     busy                             command in progress
//     rd_timeout                       (macro only) watchdog fired, sticky
module ddr_burst_rd_master
   import ddr_burst_rd_master_pkg::*;
#(
   parameter int DATA_WIDTH = DDR_DATA_WIDTH,
   parameter int ADDR_SIZE  = DDR_ADDR_SIZE,
   parameter int LEN_WIDTH  = DDR_LEN_WIDTH,
   parameter int CNT_WIDTH  = 20,
   parameter int MAX_BURST  = 64,
   parameter int FIFO_DEPTH = 128
`ifdef BURST_RD_TIMEOUT_EN
   , parameter int TIMEOUT  = 4096
`endif
) (
   input  logic                  user_clk,
   input  logic                  user_rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_SIZE-1:0]  cmd_addr,
   input  logic [CNT_WIDTH-1:0]  cmd_beats,
   output logic                  burst_read_req,
   output logic [ADDR_SIZE-1:0]  burst_read_addr,
   output logic [LEN_WIDTH-1:0]  burst_read_len,
   input  logic                  burst_read_valid,
   input  logic [DATA_WIDTH-1:0] burst_read_data,
   input  logic                  burst_read_finish,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [DATA_WIDTH-1:0] dout_data,
   output logic                  dout_last,
   output logic                  done,
   output logic                  busy
`ifdef BURST_RD_TIMEOUT_EN
   , output logic                rd_timeout
`endif
);

   localparam int BPB = bytes_per_beat(DATA_WIDTH);
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;

   state_t                r_state;
   logic [ADDR_SIZE-1:0]  r_addr;
   logic [ADDR_SIZE-1:0]  r_rd_addr;
   logic [LEN_WIDTH-1:0]  r_rd_len;
   logic [LEN_WIDTH-1:0]  r_rcv;
   logic [CNT_WIDTH-1:0]  r_rem;
   logic [CNT_WIDTH-1:0]  r_total;
   logic [CNT_WIDTH-1:0]  r_popped;
   logic                  r_req;
   logic                  r_busy;
   logic                  r_done;

   logic [CW-1:0]         w_count;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_last;
   logic                  w_space_ok;
   logic                  w_drained;
   logic [LEN_WIDTH-1:0]  w_blen;

`ifdef BURST_RD_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT + 1);
   logic [WDW-1:0]        r_wdog;
   logic                  r_rd_timeout;
   logic                  r_abort;
   assign rd_timeout = r_rd_timeout;
`endif

   assign w_blen     = (r_rem > CNT_WIDTH'(MAX_BURST)) ? LEN_WIDTH'(MAX_BURST)
                                                       : r_rem[LEN_WIDTH-1:0];
   assign w_space_ok = (CNT_WIDTH'(FIFO_DEPTH) - CNT_WIDTH'(w_count)) >= CNT_WIDTH'(w_blen);

   // Beats beyond the requested length, or outside DATA (stale bursts after
   // reset), are dropped.
   assign w_push = (r_state == ST_DATA) && burst_read_valid && (r_rcv < r_rd_len) && !w_full;
   assign w_pop  = !w_empty && dout_ready;
   assign w_last = !w_empty && r_busy && (r_popped == r_total - 1'b1);

   // The last beat may be consumed before the final finish pulse arrives,
   // so DRAIN also accepts an already-complete pop count.
`ifdef BURST_RD_TIMEOUT_EN
   assign w_drained = (w_pop && w_last) || (r_popped == r_total) || (r_abort && w_empty);
`else
   assign w_drained = (w_pop && w_last) || (r_popped == r_total);
`endif

   sync_fwft_fifo #(
      .W     (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (user_clk),
      .rst_n (user_rst_n),
      .push  (w_push),
      .din   (burst_read_data),
      .pop   (w_pop),
      .dout  (dout_data),
      .count (w_count),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         r_state      <= ST_IDLE;
         r_addr       <= '0;
         r_rd_addr    <= '0;
         r_rd_len     <= '0;
         r_rcv        <= '0;
         r_rem        <= '0;
         r_total      <= '0;
         r_popped     <= '0;
         r_req        <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
`ifdef BURST_RD_TIMEOUT_EN
         r_wdog       <= '0;
         r_rd_timeout <= 1'b0;
         r_abort      <= 1'b0;
`endif
      end else begin
         r_req  <= 1'b0;
         r_done <= 1'b0;
         if (w_push) r_rcv    <= r_rcv + 1'b1;
         if (w_pop)  r_popped <= r_popped + 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_addr   <= cmd_addr & ~ADDR_SIZE'(BPB - 1);
                  r_rem    <= cmd_beats;
                  r_total  <= cmd_beats;
                  r_popped <= '0;
`ifdef BURST_RD_TIMEOUT_EN
                  r_rd_timeout <= 1'b0;
                  r_abort      <= 1'b0;
`endif
                  if (cmd_beats == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_busy  <= 1'b1;
                     r_state <= ST_ISSUE;
                  end
               end
            end

            ST_ISSUE: begin
               if (w_space_ok) begin
                  r_req     <= 1'b1;
                  r_rd_addr <= r_addr;
                  r_rd_len  <= w_blen;
                  r_rcv     <= '0;
`ifdef BURST_RD_TIMEOUT_EN
                  r_wdog    <= '0;
`endif
                  r_state   <= ST_DATA;
               end
            end

            ST_DATA: begin
               if (burst_read_finish) begin
                  r_addr  <= r_addr + ADDR_SIZE'(r_rd_len) * ADDR_SIZE'(BPB);
                  r_rem   <= r_rem - CNT_WIDTH'(r_rd_len);
                  r_state <= (r_rem == CNT_WIDTH'(r_rd_len)) ? ST_DRAIN : ST_ISSUE;
               end
`ifdef BURST_RD_TIMEOUT_EN
               else if (r_wdog == WDW'(TIMEOUT - 1)) begin
                  r_rd_timeout <= 1'b1;
                  r_abort      <= 1'b1;
                  r_rem        <= '0;
                  r_state      <= ST_DRAIN;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
`endif
            end

            ST_DRAIN: begin
               if (w_drained) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready       = (r_state == ST_IDLE);
   assign burst_read_req  = r_req;
   assign burst_read_addr = r_rd_addr;
   assign burst_read_len  = r_rd_len;
   assign dout_valid      = !w_empty;
   assign dout_last       = w_last;
   assign done            = r_done;
   assign busy            = r_busy;

endmodule
